imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the multi-cycle RV32/RV64 datapath.
//  Produces a sign/zero-extended immediate for the I, S, B, J, U, CSR-zimm and shamt formats.
//  Format comes from an explicit immsrc code, or (AUTO_DECODE=1) from the opcode/funct3.
//  A valid/ready handshake with a 2-entry skid buffer gives full throughput under
//  backpressure. A saturating counter tracks illegal-format events.
// PARAMETERS
//  XLEN         32  immediate width; 32 or 64 only
//  AUTO_DECODE  0   1: derive format from instr[6:0]/[14:12]; immsrc is ignored
//  CNT_W        16  width of the illegal-event counter
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        instr/immsrc valid
//  in_ready   out  1        block can accept (transfer = in_valid & in_ready)
//  instr      in   32       full instruction word
//  immsrc     in   3        000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SH, 111 undefined
//  out_valid  out  1        immext/illegal valid
//  out_ready  in   1        consumer accepts (transfer = out_valid & out_ready)
//  immext     out  XLEN     extended immediate
//  illegal    out  1        format undefined or unknown opcode; immext forced to 0
//  ill_count  out  CNT_W    count of accepted illegal items, saturating
// BEHAVIOUR
//  Reset (sync, active-high): out_valid=0, in_ready=1, immext=0, illegal=0, ill_count=0.
//   Reset clears both buffer entries mid-transfer; in-flight items are dropped.
//  Extension: sign bit is instr[31], replicated to XLEN:
//   I = instr[31:20]; S = instr[31:25],[11:7]; B = [31],[7],[30:25],[11:8],0
//   J = [31],[19:12],[20],[30:21],0; U = instr[31:12]<<12, sign-extended above bit 31
//   Z = zero-extended instr[19:15]
//   SH = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64)
//   111 -> immext=0, illegal=1. Never drives X.
//  AUTO_DECODE opcode map:
//   0000011/1100111 -> I; 0010011 with funct3 001/101 -> SH, otherwise I
//   0100011 -> S; 1100011 -> B; 1101111 -> J; 0110111/0010111 -> U
//   1110011 with funct3[2]=1 -> Z, otherwise I; any other opcode -> illegal
//  Latency: 1 cycle. An item accepted in cycle N is on outputs in cycle N+1.
//  Extension logic is combinational on the input side; results are registered.
//  Skid FSM (states by occupancy):
//   EMPTY: in_ready=1, out_valid=0. Transfer in -> ONE.
//   ONE: in_ready=1, out_valid=1.
//    in only -> FULL (item goes to skid reg)
//    out only -> EMPTY
//    in and out together -> ONE (main reg reloaded)
//   FULL: in_ready=0, out_valid=1. Out transfer -> ONE (skid moves to main).
//  in_ready is a registered output; there is no combinational path from out_ready.
//  Order is strictly FIFO. Outputs stay stable while out_valid & !out_ready.
//  ill_count increments on an input transfer of an illegal item and holds at 2^CNT_W-1.
//  in_valid with in_ready=0 is ignored; the producer must hold its data.
// STRUCTURE
//  imm_pkg holds: immsrc localparams IMM_I..IMM_UNDEF, RV opcode constants,
//   and function imm_extend(instr, fmt) (XLEN via package parameter override
//   or function width argument).
//  Sub-module imm_skid_buf, parametrised by data width (XLEN+1):
//   2-entry buffer, valid/ready handshake, registered in_ready.
//  Top level: format select (mux or auto-decode), extension, counter, imm_skid_buf.
// TESTING
//  XLEN=32, immsrc=000, instr=0xFFF00093 -> immext=0xFFFFFFFF, illegal=0, 1 cycle after accept.
//  immsrc=001 0xFE20AE23 -> 0xFFFFFFFC; 010 0xFE000CE3 -> 0xFFFFFFF8.
//   011 0x001000EF -> 0x00000800; 100 0x123450B7 -> 0x12345000.
//  XLEN=64, AUTO_DECODE=1: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
//   0x123450B7 -> 0x0000000012345000; opcode 0x7F -> illegal=1, immext=0, ill_count=1.
//  out_ready=0 for 3 cycles, in_valid=1 with 3 distinct items:
//   2 accepted, in_ready=0 from the 3rd cycle.
//   Then out_ready=1 -> items emerge in order, throughput 1/cycle.
//  Streaming with out_ready=1: 10 back-to-back items -> 10 outputs on consecutive cycles.
//  reset asserted while FULL -> next cycle out_valid=0, in_ready=1, ill_count=0.
//  CNT_W=2 and 5 illegal items -> ill_count saturates at 3.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants and helpers for the pipelined RV32/RV64 immediate generator.
// Extension is always computed 64 bits wide; callers keep the low XLEN bits.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_J     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_Z     = 3'd5;
  localparam logic [2:0] IMM_SH    = 3'd6;
  localparam logic [2:0] IMM_UNDEF = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [2:0] imm_decode(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    case (instr[6:0])
      OP_LOAD, OP_JALR:  imm_decode = IMM_I;
      OP_IMM:            imm_decode = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SH : IMM_I;
      OP_STORE:          imm_decode = IMM_S;
      OP_BRANCH:         imm_decode = IMM_B;
      OP_JAL:            imm_decode = IMM_J;
      OP_LUI, OP_AUIPC:  imm_decode = IMM_U;
      OP_SYSTEM:         imm_decode = f3[2] ? IMM_Z : IMM_I;
      default:           imm_decode = IMM_UNDEF;
    endcase
  endfunction

  function automatic logic [63:0] imm_extend(input logic [31:0] instr,
                                             input logic [2:0]  fmt,
                                             input logic        rv64);
    logic s;
    s = instr[31];
    case (fmt)
      IMM_I:   imm_extend = {{52{s}}, instr[31:20]};
      IMM_S:   imm_extend = {{52{s}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_extend = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_extend = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_extend = {{32{s}}, instr[31:12], 12'b0};
      IMM_Z:   imm_extend = {59'b0, instr[19:15]};
      IMM_SH:  imm_extend = rv64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default: imm_extend = 64'b0;
    endcase
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer with registered in_ready, so out_ready never reaches in_ready
// combinationally. state | meaning: EMPTY | no item; ONE | main holds head; FULL | main + skid held.
module imm_skid_buf
  import imm_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    in_ready_d  = (state_d != SKID_FULL);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: format select, extension and illegal counting on the
// input side, one registered stage of buffering through a two-entry skid buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic             illegal,
  output logic [CNT_W-1:0] ill_count
);

  logic [2:0]       fmt;
  logic [63:0]      ext64;
  logic [XLEN-1:0]  imm_in;
  logic             ill_in;
  logic [CNT_W-1:0] ill_count_q, ill_count_d;

  always_comb begin
    fmt = immsrc;
    if (AUTO_DECODE != 0) fmt = imm_decode(instr);
  end

  assign ext64  = imm_extend(instr, fmt, XLEN == 64);
  assign ill_in = (fmt == IMM_UNDEF);

  generate
    if (XLEN == 64) begin : g_rv64
      assign imm_in = ext64;
    end else begin : g_rv32
      logic unused_hi;
      assign imm_in    = ext64[31:0];
      assign unused_hi = ^ext64[63:32];
    end
  endgenerate

  // Counts at acceptance, not at output, so backpressure cannot delay it.
  always_comb begin
    ill_count_d = ill_count_q;
    if (in_valid && in_ready && ill_in && !(&ill_count_q))
      ill_count_d = ill_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ill_count_q <= '0;
    else       ill_count_q <= ill_count_d;
  end

  assign ill_count = ill_count_q;

  imm_skid_buf #(.W(XLEN + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ill_in, imm_in}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({illegal, immext})
  );

endmodule
